// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests to
// instruction memory and hands buffered words to the core over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] alloc_cnt;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] rsp_ptr;
  logic [PW-1:0] tail_ptr;

  logic [31:0]          ent_pc   [BUF_DEPTH];
  logic [31:0]          ent_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] ent_full;

  logic          active;
  logic          credit_ok;
  logic          req_fire;
  logic          dropping;
  logic          rsp_write;
  logic          pop;
  logic [CW-1:0] inflight;
  logic [CW-1:0] redirect_drop;

  // Entries are allocated at request time, so alloc_cnt covers both the
  // words in flight and the words waiting for the core.
  always_comb begin
    active        = (state != S_IDLE);
    credit_ok     = ({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < {1'b0, DEPTH_C};
    imem_req_valid = active && credit_ok && !redirect_valid;
    imem_req_addr = fetch_pc;
    req_fire      = imem_req_valid && imem_req_ready;
    dropping      = (state == S_FLUSH) && (drop_cnt != '0) && imem_rsp_valid;
    rsp_write     = active && !redirect_valid && imem_rsp_valid &&
                    (drop_cnt == '0) && (outstanding != '0);
    inst_valid    = ent_full[head_ptr];
    inst_data     = inst_valid ? ent_data[head_ptr] : 32'h0;
    inst_pc       = inst_valid ? ent_pc[head_ptr] : 32'h0;
    pop           = inst_valid && inst_ready && !redirect_valid;
    inflight      = outstanding + drop_cnt;
    redirect_drop = inflight - CW'(imem_rsp_valid && (inflight != '0));
  end

  // Control state: a redirect wins over everything else and restarts the
  // buffer accounting, leaving the old in-flight words to be dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      alloc_cnt   <= '0;
      head_ptr    <= '0;
      rsp_ptr     <= '0;
      tail_ptr    <= '0;
    end else if (redirect_valid) begin
      state       <= (redirect_drop != '0) ? S_FLUSH : S_RUN;
      fetch_pc    <= redirect_pc & ~32'h3;
      outstanding <= '0;
      drop_cnt    <= redirect_drop;
      alloc_cnt   <= '0;
      head_ptr    <= '0;
      rsp_ptr     <= '0;
      tail_ptr    <= '0;
    end else begin
      case (state)
        S_IDLE:  state <= S_RUN;
        S_FLUSH: if ((drop_cnt == '0) || (dropping && drop_cnt == CW'(1)))
                   state <= S_RUN;
        default: state <= state;
      endcase
      if (dropping)
        drop_cnt <= drop_cnt - CW'(1);
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
        tail_ptr <= tail_ptr + PW'(1);
      end
      if (rsp_write)
        rsp_ptr <= rsp_ptr + PW'(1);
      if (pop)
        head_ptr <= head_ptr + PW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_write);
      alloc_cnt   <= alloc_cnt + CW'(req_fire) - CW'(pop);
    end
  end

  // Entry storage; request, response and pop always touch different slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_full <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        ent_pc[i]   <= 32'h0;
        ent_data[i] <= 32'h0;
      end
    end else if (redirect_valid) begin
      ent_full <= '0;
    end else begin
      if (req_fire) begin
        ent_pc[tail_ptr]   <= fetch_pc;
        ent_full[tail_ptr] <= 1'b0;
      end
      if (rsp_write) begin
        ent_data[rsp_ptr] <= imem_rsp_data;
        ent_full[rsp_ptr] <= 1'b1;
      end
      if (pop)
        ent_full[head_ptr] <= 1'b0;
    end
  end

  a_credit_cap: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, alloc_cnt} + {1'b0, drop_cnt}) <= {1'b0, DEPTH_C});
  a_out_le_alloc: assert property (@(posedge clk) disable iff (reset)
    outstanding <= alloc_cnt);

endmodule
